// File: rtl/robs_mult_seq.sv
// robs_mult_seq: sequential shift-add / Robertson multiplier, one multiplier bit per clock.
// Latency: start accepted at edge 0, done pulses in cycle WIDTH+1 (cycle 1 for a zero operand with ROBS_ZERO_SKIP_EN).
// Backpressure: none; start is only sampled in IDLE, and starts seen while busy are dropped.
//
// Optional feature macro: ROBS_ZERO_SKIP_EN (zero-operand early completion).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, aborts any operation in flight
//   start        operation request, sampled only in IDLE
//   is_signed    1 = two's-complement (Robertson), 0 = unsigned; captured with the operands
//   multiplier   operand X, captured on the accept edge
//   multiplicand operand Y, captured on the accept edge
//   busy         high in CALC and DONE
//   done         one-cycle pulse, product valid
//   product      2*WIDTH result register, held until the next result is written
module robs_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   a_q;      // accumulator with guard bit
  logic [WIDTH:0]   m_q;      // multiplicand, sign- or zero-extended at load
  logic [WIDTH-1:0] q_q;      // multiplier, shifted right as product bits arrive
  logic [CW-1:0]    cnt_q;
  logic             mode_q;   // latched is_signed

  logic             last;
  logic             zero_op;
  logic [WIDTH+1:0] sum;      // one extra bit so the unsigned carry-out is visible
  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;

  assign last = (cnt_q == '0);

`ifdef ROBS_ZERO_SKIP_EN
  assign zero_op = (multiplier == '0) || (multiplicand == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Partial-product step. In signed mode the final multiplier bit is the sign
  // bit of X, weighted -2^(WIDTH-1), hence the subtraction on the last step.
  always_comb begin
    sum = {1'b0, a_q};
    if (q_q[0]) begin
      if (mode_q && last) begin
        sum = {1'b0, a_q} - {1'b0, m_q};
      end else begin
        sum = {1'b0, a_q} + {1'b0, m_q};
      end
    end
  end

  // Right shift of {S,Q}: signed mode replicates the sign of S, unsigned mode
  // shifts in the carry-out of the WIDTH+1-bit add (the guard bit already
  // holds any WIDTH-bit carry, so this is zero in practice).
  always_comb begin
    a_nxt = {(mode_q ? sum[WIDTH] : sum[WIDTH+1]), sum[WIDTH:1]};
    q_nxt = {sum[0], q_q[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = zero_op ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= '0;
            m_q    <= is_signed ? {multiplicand[WIDTH-1], multiplicand}
                                : {1'b0, multiplicand};
            q_q    <= multiplier;
            cnt_q  <= CW'(WIDTH - 1);
            mode_q <= is_signed;
            if (zero_op) begin
              product <= '0;
            end
          end
        end
        CALC: begin
          a_q <= a_nxt;
          q_q <= q_nxt;
          if (last) begin
            product <= {a_nxt[WIDTH-1:0], q_nxt};
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/robs_mult_seq.md
Name: robs_mult_seq

Overview:
- Self-contained sequential multiplier: a parametrised successor to the split Robertson control-unit/datapath pair.
- Integrates the FSM, iteration counter, accumulator and shift path in one block.
- Adds a start/busy/done handshake and a run-time signed/unsigned mode.
- Processes one multiplier bit per clock and holds the product until the next operation. Sits on the lab bus between operand registers and the display/product register.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = two's-complement Robertson multiply, 0 = unsigned shift-add; captured with operands
- multiplier  input  WIDTH  operand X, captured on the accepted start edge
- multiplicand  input  WIDTH  operand Y, captured on the accepted start edge
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse, product valid
- product  output  2*WIDTH  result register, held until overwritten

Behaviour:
- Reset (synchronous, active-high, any state including mid-operation):
  - state=IDLE; busy=0, done=0, product=0; internal A, Q, M and count cleared.
  - The in-flight operation is discarded.
- Registers:
  - M (WIDTH+1): multiplicand, sign-extended when is_signed=1, zero-extended otherwise.
  - A (WIDTH+1): accumulator with guard bit.
  - Q (WIDTH): multiplier.
  - count: ceil(log2(WIDTH)) bits.
  - mode: latched is_signed.
- States:
  - IDLE: on start=1, load M, Q=multiplier, A=0, count=WIDTH-1, mode=is_signed, go to CALC. With start=0, stay. product holds.
  - CALC, one edge per bit:
    - If Q[0]=1, S=A+M, or S=A-M when mode=1 and count==0 (Robertson sign correction); else S=A.
    - Shift {S,Q} right by one.
    - mode=1: new A MSB = S MSB (arithmetic).
    - mode=0: new A MSB = carry-out of the WIDTH+1-bit add, which is always 0 for unsigned; the guard bit keeps the carry.
    - If count==0, write product={A_new[WIDTH-1:0],Q_new} and go to DONE; else count-=1.
  - DONE: done=1 for exactly this cycle, busy=1, then IDLE.
- Latency: start accepted at edge 0 → WIDTH CALC edges → done high in cycle WIDTH+1. Back-to-back throughput is one op per WIDTH+2 cycles.
- Handshake and edge cases:
  - start while busy (CALC/DONE) is ignored and not queued.
  - start held high continuously re-triggers on each return to IDLE.
  - Operand and is_signed changes after the accept edge have no effect.
- Arithmetic: all add/sub is WIDTH+1 bits with the guard bit, so no overflow for any operand pair, including -2^(WIDTH-1) * -2^(WIDTH-1).
- Boundary: WIDTH=2 must work; count never wraps because the state leaves CALC at count==0.

Optional Feature:
- Macro: ROBS_ZERO_SKIP_EN.
- Defined: in IDLE, if start=1 and multiplier==0 or multiplicand==0:
  - Go directly to DONE with product=0 written on the accept edge.
  - done is high in cycle 1 (latency 1); busy is high for that one cycle.
  - Non-zero operands behave exactly as above.
- Undefined: no zero detection; every operation takes the full WIDTH-cycle CALC sequence, including zero operands (product=0 at cycle WIDTH+1).

Test Plan:
- WIDTH=8, is_signed=1, X=-3 (8'hFD), Y=5 → product 16'hFFF1, done pulse exactly in cycle 9 after accept, busy high cycles 1-9.
- is_signed=1, X=8'h80, Y=8'h80 → 16'h4000; X=8'h7F, Y=8'hFF → 16'hFF81 (sign correction on last step).
- is_signed=0, X=8'hFF, Y=8'hFF → 16'hFE01; X=8'h80, Y=8'h02 → 16'h0100 (guard-bit carry path).
- Start 3*4, pulse start with 9*9 at cycle 4 → 9*9 ignored, product 16'h000C; then start 9*9 in IDLE → 16'h0051.
- Start -3*5, assert reset at cycle 5 → next cycle busy=0, done=0, product=0; new 2*2 → 16'h0004 with normal latency.
- X=0, Y=8'h55: with ROBS_ZERO_SKIP_EN → done in cycle 1, product 0; without it → done in cycle 9, product 0.
